seq_shift_register: RTL and testbench

Parametrised multi-cycle shift register with parallel load, four shift modes, a programmable shift amount and an optional frozen low segment. It extends the codebase's load/shift-right register used in the iterative arithmetic datapaths. A controller FSM performs one bit-shift per clock and reports completion with a busy/done handshake. Status flags (zero, upper-segment-zero, mid tap) feed the datapath sequencer directly.

---
 rtl/shreg_pkg.sv | 15 +
 rtl/seq_shift_register_if.sv | 31 +++
 rtl/shreg_step.sv | 34 +++
 rtl/seq_shift_register.sv | 75 +++++++
 tb/tb_seq_shift_register.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/shreg_pkg.sv
// shreg_pkg: shared mode encodings and controller states for the shift register
package shreg_pkg;
    typedef enum logic [1:0] {
        SH_LSR = 2'b00,
        SH_ASR = 2'b01,
        SH_LSL = 2'b10,
        SH_ROR = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;
endpackage

// File: rtl/seq_shift_register_if.sv
// seq_shift_register_if: request/data/status bundle between sequencer and shift register
interface seq_shift_register_if
    import shreg_pkg::*;
#(
    parameter int N  = 16,
    parameter int AW = $clog2(N) + 1
);
    logic          ld;
    logic [N-1:0]  pin;
    logic          start;
    mode_t         mode;
    logic [AW-1:0] amt;
    logic          freeze_lo;
    logic          sin;
    logic [N-1:0]  pout;
    logic          busy;
    logic          done;
    logic          zero;
    logic          hi_zero;
    logic          mid;

    modport master (
        output ld, pin, start, mode, amt, freeze_lo, sin,
        input  pout, busy, done, zero, hi_zero, mid
    );

    modport slave (
        input  ld, pin, start, mode, amt, freeze_lo, sin,
        output pout, busy, done, zero, hi_zero, mid
    );
endinterface

// File: rtl/shreg_step.sv
// shreg_step: one-bit shift of the whole register or of its upper field with the low segment held
module shreg_step
    import shreg_pkg::*;
#(
    parameter int N     = 16,
    parameter int SPLIT = N / 2
) (
    input  logic [N-1:0] q,
    input  mode_t        mode,
    input  logic         sin,
    input  logic         frz,
    output logic [N-1:0] nxt
);
    localparam int W = N - SPLIT;

    logic [N-1:0] full;
    logic [W-1:0] h;
    logic [W-1:0] hs;

    assign h = q[N-1:SPLIT];

    assign full = mode == SH_LSR ? {sin, q[N-1:1]} :
                  mode == SH_ASR ? {q[N-1], q[N-1:1]} :
                  mode == SH_LSL ? {q[N-2:0], sin} :
                                   {q[0], q[N-1:1]};

    // when frozen, the field's lowest bit is h[0], so nothing crosses the split
    assign hs = mode == SH_LSR ? {sin, h[W-1:1]} :
                mode == SH_ASR ? {h[W-1], h[W-1:1]} :
                mode == SH_LSL ? {h[W-2:0], sin} :
                                 {h[0], h[W-1:1]};

    assign nxt = frz ? {hs, q[SPLIT-1:0]} : full;
endmodule

// File: rtl/seq_shift_register.sv
// seq_shift_register: loadable register shifted one bit per clock under a busy/done controller
module seq_shift_register
    import shreg_pkg::*;
#(
    parameter int N     = 16,
    parameter int SPLIT = N / 2,
    parameter int MID   = N / 2 + 1
) (
    input logic                 clk,
    input logic                 rst,
    seq_shift_register_if.slave bus
);
    localparam int AW = $clog2(N) + 1;

    state_t        state;
    logic [N-1:0]  q;
    logic [N-1:0]  nxt;
    logic [AW-1:0] cnt;
    logic [AW-1:0] k;
    mode_t         mode_r;
    logic          frz;
    logic          busy_r;
    logic          done_r;

    assign k = bus.amt > AW'(N) ? AW'(N) : bus.amt;

    shreg_step #(.N(N), .SPLIT(SPLIT)) u_step (
        .q    (q),
        .mode (mode_r),
        .sin  (bus.sin),
        .frz  (frz),
        .nxt  (nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            q      <= '0;
            cnt    <= '0;
            mode_r <= SH_LSR;
            frz    <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else if (state == SHIFT) begin
            q   <= nxt;
            cnt <= cnt - 1'b1;
            if (cnt == AW'(1)) begin
                state  <= DONE;
                busy_r <= 1'b0;
                done_r <= 1'b1;
            end
        end else if (bus.ld) begin
            q      <= bus.pin;
            state  <= IDLE;
            done_r <= 1'b0;
        end else if (bus.start) begin
            mode_r <= bus.mode;
            frz    <= bus.freeze_lo;
            cnt    <= k;
            state  <= k == '0 ? DONE : SHIFT;
            busy_r <= k != '0;
            done_r <= k == '0;
        end else begin
            state  <= IDLE;
            done_r <= 1'b0;
        end
    end

    assign bus.pout    = q;
    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.zero    = ~|q;
    assign bus.hi_zero = ~|q[N-1:SPLIT];
    assign bus.mid     = q[MID];
endmodule

// File: tb/tb_seq_shift_register.sv
// tb_seq_shift_register: directed scoreboard bench for the N=16 shift register
module tb_seq_shift_register;
    import shreg_pkg::*;

    localparam int N = 16;
    localparam int SPLIT = 8;
    localparam int MID = 9;

    typedef struct {
        logic [15:0] pout;
        int          lat;
        int          bsy;
        bit          has_done;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    logic [15:0] cur = '0;
    exp_t sb[$];

    seq_shift_register_if #(.N(N)) bus ();

    seq_shift_register #(.N(N), .SPLIT(SPLIT), .MID(MID)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [15:0] ref_shift(input logic [15:0] v0, input mode_t md, input int k,
                                              input logic s, input logic fz);
        logic [15:0] v;
        logic [15:0] o;
        int lo;
        v = v0;
        lo = fz ? SPLIT : 0;
        for (int st = 0; st < k; st++) begin
            o = v;
            for (int b = lo; b < 16; b++) begin
                case (md)
                    SH_LSR: o[b] = (b == 15) ? s : v[(b == 15) ? 15 : b + 1];
                    SH_ASR: o[b] = (b == 15) ? v[15] : v[(b == 15) ? 15 : b + 1];
                    SH_LSL: o[b] = (b == lo) ? s : v[(b == 0) ? 0 : b - 1];
                    default: o[b] = (b == 15) ? v[lo] : v[(b == 15) ? 15 : b + 1];
                endcase
            end
            v = o;
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic flags(input string tag);
        chk({tag, "_zero"}, bus.zero, cur == 16'h0);
        chk({tag, "_hi_zero"}, bus.hi_zero, cur[15:8] == 8'h0);
        chk({tag, "_mid"}, bus.mid, cur[MID]);
    endtask

    task automatic load(input logic [15:0] v);
        bus.ld = 1'b1;
        bus.pin = v;
        tick();
        bus.ld = 1'b0;
        cur = v;
        chk("load_pout", bus.pout, v);
    endtask

    task automatic run(input string tag, input mode_t md, input logic [4:0] am, input logic s,
                       input logic fz, input int ld_at, input int rst_at);
        exp_t e;
        int k;
        int cyc;
        int bcnt;
        bit seen;
        k = (am > 16) ? 16 : int'(am);
        e.pout = (rst_at > 0) ? 16'h0 : ref_shift(cur, md, k, s, fz);
        e.lat = k + 1;
        e.bsy = k;
        e.has_done = (rst_at == 0);
        sb.push_back(e);
        cur = e.pout;
        bus.start = 1'b1;
        bus.mode = md;
        bus.amt = am;
        bus.sin = s;
        bus.freeze_lo = fz;
        tick();
        bus.start = 1'b0;
        cyc = 1;
        bcnt = 0;
        seen = 0;
        while (cyc <= 40) begin
            if (bus.done) begin
                seen = 1;
                break;
            end
            bcnt += int'(bus.busy);
            bus.ld = (cyc == ld_at);
            bus.pin = 16'hFFFF;
            rst = (cyc == rst_at);
            tick();
            cyc++;
        end
        rst = 1'b0;
        bus.ld = 1'b0;
        e = sb.pop_front();
        if (e.has_done) begin
            chk({tag, "_done_seen"}, seen, 1);
            chk({tag, "_latency"}, cyc, e.lat);
            chk({tag, "_busy_cycles"}, bcnt, e.bsy);
            chk({tag, "_pout"}, bus.pout, e.pout);
            tick();
            chk({tag, "_done_pulse"}, bus.done, 1'b0);
        end else begin
            chk({tag, "_no_done"}, seen, 0);
            chk({tag, "_pout"}, bus.pout, e.pout);
            chk({tag, "_busy"}, bus.busy, 1'b0);
        end
        flags(tag);
    endtask

    initial begin
        bus.ld = 1'b0;
        bus.pin = '0;
        bus.start = 1'b0;
        bus.mode = SH_LSR;
        bus.amt = '0;
        bus.freeze_lo = 1'b0;
        bus.sin = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_pout", bus.pout, 16'h0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        flags("rst");

        load(16'hA5C3);
        flags("ld_a5c3");
        run("lsr4", SH_LSR, 5'd4, 1'b1, 1'b0, 0, 0);
        chk("lsr4_const", bus.pout, 16'hFA5C);

        load(16'h8001);
        run("asr20", SH_ASR, 5'd20, 1'b0, 1'b0, 0, 0);
        chk("asr20_const", bus.pout, 16'hFFFF);

        load(16'h1234);
        run("ror4_frz", SH_ROR, 5'd4, 1'b0, 1'b1, 0, 0);
        chk("ror4_const", bus.pout, 16'h2134);

        load(16'h00F0);
        run("lsl0", SH_LSL, 5'd0, 1'b0, 1'b0, 0, 0);

        load(16'h9C3A);
        run("lsl5_frz", SH_LSL, 5'd5, 1'b1, 1'b1, 0, 0);
        run("ror7", SH_ROR, 5'd7, 1'b0, 1'b0, 0, 0);
        load(16'h8F00);
        run("asr5_frz", SH_ASR, 5'd5, 1'b0, 1'b1, 0, 0);
        run("lsl16", SH_LSL, 5'd16, 1'b0, 1'b0, 0, 0);

        bus.ld = 1'b1;
        bus.pin = 16'h5555;
        bus.start = 1'b1;
        bus.amt = 5'd3;
        bus.mode = SH_LSR;
        tick();
        bus.ld = 1'b0;
        bus.start = 1'b0;
        cur = 16'h5555;
        chk("ldstart_pout", bus.pout, 16'h5555);
        chk("ldstart_busy", bus.busy, 1'b0);
        chk("ldstart_done", bus.done, 1'b0);
        tick();
        chk("ldstart_done2", bus.done, 1'b0);
        chk("ldstart_pout2", bus.pout, 16'h5555);

        run("ld_ignored", SH_LSR, 5'd8, 1'b0, 1'b0, 3, 0);
        chk("ld_ignored_const", bus.pout, 16'h0055);

        run("rst_mid", SH_LSR, 5'd8, 1'b1, 1'b0, 0, 3);
        chk("rst_mid_zero", bus.zero, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
